// File: rtl/decoder_arb_pkg.sv
// Shared definitions for the round-robin arbiter that drives the 3-to-8 decoder.
// Holds the requester count, index width, FSM states and the winner search.
package decoder_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  // Scans ptr, ptr+1, ... modulo 8 and returns the first requesting index.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/decoder_3to8.sv
// Classic 3-to-8 line decoder with enable; a is the MSB of the select code.
// Exactly one output is high when enabled, all outputs are low otherwise.
module decoder_3to8 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (en) begin
      y[{a, b, c}] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for eight requesters; the grant vector is the output of a
// shared 3-to-8 decoder driven from the registered winner index and busy flag.
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic [IDX_W-1:0] idx_next;
  logic [CW-1:0]    hold_cnt, hold_cnt_next;
  logic             timeout_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      grant_idx <= idx_next;
      hold_cnt  <= hold_cnt_next;
      timeout   <= timeout_next;
    end
  end

  // done takes priority over the last hold cycle, so a collision never pulses timeout.
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    idx_next      = grant_idx;
    hold_cnt_next = hold_cnt;
    timeout_next  = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (|req) begin
          idx_next      = rr_pick(req, ptr);
          hold_cnt_next = '0;
          state_next    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          state_next = ARB_IDLE;
          ptr_next   = grant_idx + 3'd1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next   = ARB_IDLE;
          ptr_next     = grant_idx + 3'd1;
          timeout_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign busy = (state == ARB_BUSY);

  decoder_3to8 u_decoder (
    .a  (grant_idx[2]),
    .b  (grant_idx[1]),
    .c  (grant_idx[0]),
    .en (busy),
    .y  (grant)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: each step drives inputs, queues the
// expected outputs, and compares them one time unit after the clock edge.
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.MAX_HOLD(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  task automatic push_exp(input string tag, input logic [7:0] g, input logic [2:0] i,
                          input logic b, input logic t);
    exp_t e;
    e.tag     = tag;
    e.grant   = g;
    e.idx     = i;
    e.busy    = b;
    e.timeout = t;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    total++;
    assert (grant === e.grant) else begin
      bad++;
      $error("[TB] FAIL %s grant: got %h expected %h", e.tag, grant, e.grant);
    end
    total++;
    assert (grant_idx === e.idx) else begin
      bad++;
      $error("[TB] FAIL %s grant_idx: got %0d expected %0d", e.tag, grant_idx, e.idx);
    end
    total++;
    assert (busy === e.busy) else begin
      bad++;
      $error("[TB] FAIL %s busy: got %b expected %b", e.tag, busy, e.busy);
    end
    total++;
    assert (timeout === e.timeout) else begin
      bad++;
      $error("[TB] FAIL %s timeout: got %b expected %b", e.tag, timeout, e.timeout);
    end
  endtask

  // Drive one cycle of inputs, then compare after the following rising edge.
  task automatic apply_stimulus(input logic [7:0] r, input logic d, input string tag,
                                input logic [7:0] g, input logic [2:0] i,
                                input logic b, input logic t);
    req  = r;
    done = d;
    push_exp(tag, g, i, b, t);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] onehot;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    #2;
    push_exp("reset_init", 8'h00, 3'd0, 1'b0, 1'b0);
    check_output();
    @(negedge clk);
    rst = 1'b0;

    // Rotation: every requester asking, released on each busy cycle.
    for (int k = 0; k < 9; k++) begin
      onehot = 8'h01 << (k % 8);
      apply_stimulus(8'hFF, 1'b0, $sformatf("rot_grant%0d", k), onehot, 3'(k % 8), 1'b1, 1'b0);
      apply_stimulus(8'hFF, 1'b1, $sformatf("rot_idle%0d", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
    end

    // Single requester 5 holds three cycles while its request is dropped.
    apply_stimulus(8'h20, 1'b0, "single_grant", 8'h20, 3'd5, 1'b1, 1'b0);
    apply_stimulus(8'h00, 1'b0, "single_hold1", 8'h20, 3'd5, 1'b1, 1'b0);
    apply_stimulus(8'h00, 1'b0, "single_hold2", 8'h20, 3'd5, 1'b1, 1'b0);
    apply_stimulus(8'h00, 1'b1, "single_release", 8'h00, 3'd5, 1'b0, 1'b0);
    apply_stimulus(8'h00, 1'b1, "idle_done_ignored", 8'h00, 3'd5, 1'b0, 1'b0);

    // Pointer wrap: after serving 3 the search starts at 4.
    apply_stimulus(8'h08, 1'b0, "wrap_serve3", 8'h08, 3'd3, 1'b1, 1'b0);
    apply_stimulus(8'h00, 1'b1, "wrap_release3", 8'h00, 3'd3, 1'b0, 1'b0);
    apply_stimulus(8'h0A, 1'b0, "wrap_pick1", 8'h02, 3'd1, 1'b1, 1'b0);
    apply_stimulus(8'h00, 1'b1, "wrap_release1", 8'h00, 3'd1, 1'b0, 1'b0);

    // Timeout: grant visible for exactly 15 cycles, then a one-cycle pulse.
    apply_stimulus(8'h01, 1'b0, "to_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < 14; k++) begin
      apply_stimulus(8'h01, 1'b0, $sformatf("to_hold%0d", k + 2), 8'h01, 3'd0, 1'b1, 1'b0);
    end
    apply_stimulus(8'h01, 1'b0, "to_revoke", 8'h00, 3'd0, 1'b0, 1'b1);
    apply_stimulus(8'h01, 1'b0, "to_regrant0", 8'h01, 3'd0, 1'b1, 1'b0);

    // Collision: done on the 15th hold cycle releases without a timeout pulse.
    for (int k = 0; k < 14; k++) begin
      apply_stimulus(8'h01, 1'b0, $sformatf("col_hold%0d", k + 2), 8'h01, 3'd0, 1'b1, 1'b0);
    end
    apply_stimulus(8'h01, 1'b1, "col_release", 8'h00, 3'd0, 1'b0, 1'b0);
    apply_stimulus(8'h03, 1'b0, "after_to_pick1", 8'h02, 3'd1, 1'b1, 1'b0);
    apply_stimulus(8'h00, 1'b1, "after_to_release", 8'h00, 3'd1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant, then search restarts at 0.
    apply_stimulus(8'hFF, 1'b0, "pre_reset_grant", 8'h04, 3'd2, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    push_exp("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    check_output();
    #3;
    rst = 1'b0;
    apply_stimulus(8'hFF, 1'b0, "post_reset_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    apply_stimulus(8'hFF, 1'b1, "post_reset_release", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter sharing the 3-to-8 decoder among eight requesters. It accepts an 8-bit request vector and picks one winner. It drives the decoder's select inputs (A, B, C) and enable from registered state, so the decoder's one-hot output is the grant vector. A grant is held until the owner signals `done` or a hold timeout expires.

## Interface
Parameters:
- `MAX_HOLD`, default 15: maximum number of cycles one grant may be held (legal range 1..255).
- `CW`, default `$clog2(MAX_HOLD+1)`: hold counter width.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req`  in  8: request vector; bit i = requester i.
- `done`  in  1: current owner releases the grant; sampled only in BUSY.
- `grant`  out  8: one-hot grant, taken from decoder outputs Y7..Y0; all zero when idle.
- `grant_idx`  out  3: index of the current or last winner.
- `busy`  out  1: a grant is active; drives the decoder `en`.
- `timeout`  out  1: one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- Two states, IDLE and BUSY.
- Round-robin pointer `ptr` (3 bits): search starts at `ptr` and goes `ptr`, `ptr+1`, …, wrapping modulo 8. The first set `req` bit wins.
- **IDLE with `|req`:** register the winner into `grant_idx`, set `busy=1`, clear `hold_cnt`, go to BUSY.
- **IDLE with no request:** stay in IDLE; all outputs hold.
- **BUSY with `done=1`:** go to IDLE, `busy=0`, `ptr <= grant_idx+1` (3-bit wrap; 7 goes to 0).
- **BUSY with `done=0` and `hold_cnt == MAX_HOLD-1`:** go to IDLE, `busy=0`, `timeout=1` for one cycle, `ptr <= grant_idx+1`.
- **BUSY otherwise:** `hold_cnt <= hold_cnt+1`.
- `done` together with the last hold cycle: `done` wins and there is no `timeout` pulse.
- While BUSY, changes on `req` (including the owner dropping its request) are ignored. The grant persists until `done` or timeout.
- `done` in IDLE is ignored.
- `grant_idx` keeps its last value in IDLE. `grant` is zero in IDLE because decoder `en = busy`.
- Decoder hookup: `A = grant_idx[2]`, `B = grant_idx[1]`, `C = grant_idx[0]`.

## Timing
- Reset values (applied immediately on `rst` high, independent of `clk`): state IDLE, `ptr=0`, `grant_idx=0`, `busy=0`, `grant=8'h00`, `timeout=0`, `hold_cnt=0`.
- Reset asserted mid-BUSY revokes the grant asynchronously. After release, the first arbitration searches from index 0.
- Grant latency: `req` sampled at edge k in IDLE, `grant` and `busy` valid after edge k. One cycle, registered, no combinational `req`→`grant` path.
- Release latency: `done` sampled at edge k, `grant=0` after edge k.
- At least one IDLE cycle separates consecutive grants, so the minimum grant period is 2 cycles.
- Maximum hold: `grant` is high for exactly `MAX_HOLD` cycles. `timeout` is high during the first IDLE cycle after revocation.
- Fairness: with all eight requesting continuously, each requester gets one grant in every 8 grants.

## Structure
- Shared package `decoder_arb_pkg` holds:
  - `N_REQ=8` and `IDX_W=3`;
  - the state enum `{ARB_IDLE, ARB_BUSY}`;
  - the function `rr_pick(req, ptr)` returning the 3-bit winner index.
- One sub-module: an instance of the existing `decoder_3to8`, which produces `grant` from `grant_idx` and `busy`. There is no separate one-hot logic in this block.
- Sequential logic: the state, `ptr`, `grant_idx`, `hold_cnt` and `timeout` registers, all in a single async-reset always block.

## Test plan
- **Reset check:** assert `rst` mid-simulation with `req=8'hFF` → `grant=8'h00`, `busy=0`, `timeout=0` before the next `clk` edge.
- **Single requester:** `req=8'h20`, then `done` 3 cycles later → `grant=8'h20` and `grant_idx=5` one edge after the request, held 3 cycles, `grant=8'h00` the edge after `done`.
- **Rotation:** `req=8'hFF` with `done` pulsed on every BUSY cycle → `grant_idx` sequence 0,1,2,3,4,5,6,7,0, with one IDLE cycle between each.
- **Pointer wrap:** after serving index 3, present `req=8'h0A` → winner is 1, not 3, because the search runs 4,5,6,7,0,1.
- **Timeout:** `MAX_HOLD=15`, `req=8'h01`, `done` held low → `grant=8'h01` for exactly 15 cycles, one-cycle `timeout` pulse, and the next grant goes to requester 0 only if no other bit is set.
- **Collision:** `done` asserted on the 15th hold cycle → release with `timeout` staying 0.
